// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared light codes and phase states for the intersection blocks
package traffic_pkg;

    // Light codes seen by the display and peak-mode logic
    localparam logic [2:0] REDL    = 3'd1;
    localparam logic [2:0] GREENL  = 3'd2;
    localparam logic [2:0] YELLOWL = 3'd3;
    localparam logic [2:0] ONLINEL = 3'd4;

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        SUB_G  = 3'd2,
        SUB_Y  = 3'd3,
        FLASH  = 3'd4
    } phase_state_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - clk prescaler producing a one-cycle strobe every CLOCK_HZ enabled cycles
// Ports: clk, rst (async, active-high), enable (low freezes the count), tick (strobe).
module tick_gen #(
    parameter int CLOCK_HZ = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int PW = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLOCK_HZ - 1);

    logic [PW-1:0] pre;

    // Strobe is decoded from the count so it lines up with the wrap cycle
    assign tick = enable && (pre == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (enable) begin
            if (pre == LAST) begin
                pre <= '0;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - main/sub road phase sequencer with demand truncation and night flash
// Ports: clk, rst (async, active-high), enable, night, car_sub, ped_req in;
//        main/sub light codes (3b), main/sub seconds remaining (5b), ped_ack, tick out.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int CLOCK_HZ   = 5,
    parameter int GREENT     = 16,
    parameter int SUB_GREENT = 10,
    parameter int YELLOWT    = 3,
    parameter int MIN_GREENT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       night,
    input  logic       car_sub,
    input  logic       ped_req,
    output logic [2:0] main_light_state,
    output logic [2:0] sub_light_state,
    output logic [4:0] main_rest_time,
    output logic [4:0] sub_rest_time,
    output logic       ped_ack,
    output logic       tick
);

    localparam logic [4:0] GREEN_LD  = 5'(GREENT);
    localparam logic [4:0] SUBG_LD   = 5'(SUB_GREENT);
    localparam logic [4:0] YEL_LD    = 5'(YELLOWT);
    localparam logic [4:0] MIN_LD    = 5'(MIN_GREENT);

    phase_state_t state;
    logic [4:0]   cnt;
    logic         ped_lat;
    logic         tick_i;
    logic         demand;
    logic         enter_sub;

    tick_gen #(
        .CLOCK_HZ (CLOCK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick_i)
    );

    assign tick      = tick_i;
    assign demand    = car_sub | ped_lat;
    // Night has priority, so a night request on the last yellow second blocks SUB_G entry
    assign enter_sub = tick_i && !night && (state == MAIN_Y) && (cnt == 5'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MAIN_G;
            cnt     <= GREEN_LD;
            ped_lat <= 1'b0;
            ped_ack <= 1'b0;
        end else begin
            ped_ack <= enter_sub && ped_lat;

            // Clear on SUB_G entry beats a coincident new request
            if (enter_sub) begin
                ped_lat <= 1'b0;
            end else if (ped_req && (state != SUB_G)) begin
                ped_lat <= 1'b1;
            end

            if (tick_i) begin
                if (night && (state != FLASH)) begin
                    state <= FLASH;
                    cnt   <= 5'd0;
                end else if (state == FLASH) begin
                    if (!night) begin
                        state <= MAIN_G;
                        cnt   <= GREEN_LD;
                    end
                end else if (cnt == 5'd1) begin
                    case (state)
                        MAIN_G: begin
                            if (demand) begin
                                state <= MAIN_Y;
                                cnt   <= YEL_LD;
                            end else begin
                                cnt   <= GREEN_LD;
                            end
                        end
                        MAIN_Y: begin
                            state <= SUB_G;
                            cnt   <= SUBG_LD;
                        end
                        SUB_G: begin
                            state <= SUB_Y;
                            cnt   <= YEL_LD;
                        end
                        default: begin
                            state <= MAIN_G;
                            cnt   <= GREEN_LD;
                        end
                    endcase
                end else if ((state == MAIN_G) && demand && (cnt > MIN_LD)) begin
                    cnt <= MIN_LD;
                end else begin
                    cnt <= cnt - 5'd1;
                end
            end
        end
    end

    // Red head shows time until it turns green: add the other road's yellow while it is green
    always_comb begin
        main_light_state = ONLINEL;
        sub_light_state  = ONLINEL;
        main_rest_time   = 5'd0;
        sub_rest_time    = 5'd0;
        case (state)
            MAIN_G: begin
                main_light_state = GREENL;
                sub_light_state  = REDL;
                main_rest_time   = cnt;
                sub_rest_time    = cnt + YEL_LD;
            end
            MAIN_Y: begin
                main_light_state = YELLOWL;
                sub_light_state  = REDL;
                main_rest_time   = cnt;
                sub_rest_time    = cnt;
            end
            SUB_G: begin
                main_light_state = REDL;
                sub_light_state  = GREENL;
                main_rest_time   = cnt + YEL_LD;
                sub_rest_time    = cnt;
            end
            SUB_Y: begin
                main_light_state = REDL;
                sub_light_state  = YELLOWL;
                main_rest_time   = cnt;
                sub_rest_time    = cnt;
            end
            default: begin
                main_light_state = ONLINEL;
                sub_light_state  = ONLINEL;
                main_rest_time   = 5'd0;
                sub_rest_time    = 5'd0;
            end
        endcase
    end

endmodule
